nibble_serial_adder16: RTL and testbench

NIBBLE_SERIAL_ADDER16 -- requirements
Module: nibble_serial_adder16

---
 rtl/nibble_serial_adder16.sv | 135 +++++++++++++
 tb/tb_nibble_serial_adder16.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder16.sv
`default_nettype none
// ============================================================================
// nibble_serial_adder16 : (a+b+cin) computed one nibble per cycle through a
//                         single 4-bit full adder
// Revision: 1.0
// ============================================================================

module fa4 (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] S,
   output logic       Cout
);
   assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
endmodule

module nibble_serial_adder16 #(
   parameter int N_NIB = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*N_NIB-1:0]   a,
   input  logic [4*N_NIB-1:0]   b,
   input  logic                 cin,
   output logic                 busy,
   output logic                 done,
   output logic [4*N_NIB-1:0]   sum,
   output logic                 cout
);
   localparam int W     = 4 * N_NIB;
   localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [W-1:0]     op_a;
   logic [W-1:0]     op_b;
   logic [W-1:0]     psum;
   logic [W-1:0]     psum_next;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       fa_s;
   logic             fa_cout;
   logic             last_nib;

   assign last_nib = (idx == IDX_W'(N_NIB - 1));

   // Nibble select and partial-sum merge use constant slices per nibble.
   always_comb begin
      nib_a     = 4'h0;
      nib_b     = 4'h0;
      psum_next = psum;
      for (int n = 0; n < N_NIB; n++) begin
         if (idx == IDX_W'(n)) begin
            nib_a                = op_a[4*n +: 4];
            nib_b                = op_b[4*n +: 4];
            psum_next[4*n +: 4]  = fa_s;
         end
      end
   end

   fa4 u_fa4 (
      .A    (nib_a),
      .B    (nib_b),
      .Cin  (carry),
      .S    (fa_s),
      .Cout (fa_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_nib) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == DONE);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx   <= '0;
         carry <= 1'b0;
         op_a  <= '0;
         op_b  <= '0;
         psum  <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_a  <= a;
                  op_b  <= b;
                  carry <= cin;
                  idx   <= '0;
               end
            end
            RUN: begin
               psum  <= psum_next;
               carry <= fa_cout;
               idx   <= idx + 1'b1;
               // Published result changes only when the last nibble lands.
               if (last_nib) begin
                  sum  <= psum_next;
                  cout <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder16.sv
`default_nettype none
// ============================================================================
// tb_nibble_serial_adder16 : directed and randomized checks against a+b+cin
// Revision: 1.0
// ============================================================================
module tb_nibble_serial_adder16;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;

   int          checks = 0;
   int          failures = 0;
   logic [16:0] last_res = '0;

   nibble_serial_adder16 #(.N_NIB(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one addition from IDLE and follow it through to IDLE again.
   task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_, input logic tcin);
      logic [16:0] exp;
      int          lat;
      exp = {1'b0, ta} + {1'b0, tb_} + {16'h0, tcin};
      @(negedge clk);
      a = ta; b = tb_; cin = tcin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         check({tag, "_busy_run"}, {31'b0, busy}, 32'd1);
         check({tag, "_hold"}, {15'b0, cout, sum}, {15'b0, last_res});
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, 32'd4);
      check({tag, "_result"}, {15'b0, cout, sum}, {15'b0, exp});
      check({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
      @(negedge clk);
      check({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
      check({tag, "_done_once"}, {31'b0, done}, 32'd0);
      check({tag, "_held"}, {15'b0, cout, sum}, {15'b0, exp});
      last_res = exp;
   endtask

   task automatic count_done(input string tag, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      check(tag, pulses, 32'd0);
   endtask

   initial begin : stim
      logic [16:0] q[$];
      logic [16:0] e;
      int          lat;

      // Reset with start asserted
      @(negedge clk);
      rst = 1'b1; start = 1'b1; a = 16'h5555; b = 16'hAAAA; cin = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_sum", {16'b0, sum}, 32'h0);
      check("rst_cout", {31'b0, cout}, 32'd0);
      rst = 1'b0; start = 1'b0;
      count_done("idle_no_done", 3);
      check("idle_sum", {15'b0, cout, sum}, 32'h0);

      op("basic", 16'h00FF, 16'h0001, 1'b0);
      op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1);
      op("msb_ovf", 16'h8000, 16'h8000, 1'b0);

      // Start during RUN is ignored and late input changes have no effect
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      lat = 2;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check("ign_latency", lat, 32'd4);
      check("ign_result", {15'b0, cout, sum}, 32'h02345);
      count_done("ign_single_done", 8);
      check("ign_held", {15'b0, cout, sum}, 32'h02345);
      last_res = 17'h02345;

      // Abort mid-RUN
      @(negedge clk);
      a = 16'hABCD; b = 16'h1111; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      check("abort_sum", {15'b0, cout, sum}, 32'h0);
      count_done("abort_no_done", 8);
      last_res = '0;
      op("post_abort", 16'h0001, 16'h0002, 1'b1);

      // Back-to-back with start held high and random operands every cycle
      for (int c = 0; c < 6 * 1000; c++) begin
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(1, 0));
         start = 1'b1;
         if (c % 6 == 0) q.push_back({1'b0, a} + {1'b0, b} + {16'h0, cin});
         @(negedge clk);
         check("tput_done", {31'b0, done}, {31'b0, (c % 6 == 4)});
         if (c % 6 == 4) begin
            e = (q.size() > 0) ? q.pop_front() : 17'h0;
            check("tput_result", {15'b0, cout, sum}, {15'b0, e});
         end
      end
      start = 1'b0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
